vga_sync_decoder: RTL and testbench
===================================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameters: C_H_SYNC_PULSE 96 (hs low ticks); C_H_BACK_PORCH 48 (ticks); C_H_ACTIVE_TIME 640 (ticks); C_H_LINE_PERIOD 800 (ticks/line); C_V_SYNC_PULSE 2 (vs low lines); C_V_BACK_PORCH 33 (lines); C_V_ACTIVE_TIME 480 (lines); C_V_FRAME_PERIOD 525 (lines/frame); C_LOCK_FRAMES 2 (good frames to lock).
REQ-002 I_clk  in  1  system clock, 50 MHz; all logic on rising edge.
REQ-003 I_rst_n  in  1  asynchronous, active-low reset.
REQ-004 I_pix_ce  in  1  pixel-tick enable, one I_clk cycle wide; I_hs/I_vs/RGB are sampled only on I_pix_ce cycles.
REQ-005 I_hs, I_vs  in  1 each  sync inputs, active low, synchronous to I_clk.
REQ-006 I_red, I_green, I_blue  in  5/6/5  pixel colour.
REQ-007 O_x  out  10  active-area column; O_y  out  9  active-area row.
REQ-008 O_de  out  1  active-pixel strobe; O_red/O_green/O_blue  out  5/6/5  registered colour.
REQ-009 O_locked  out  1  timing matches parameters; O_err  out  1  one-I_clk-cycle pulse per timing violation.
REQ-010 O_line_period  out  12  last measured line length (ticks); O_frame_lines  out  12  last measured frame length (lines).

Function
REQ-011 Tick = I_clk cycle with I_pix_ce=1; all counters, edge detectors and measurements SHALL advance only on ticks.
REQ-012 hs falling edge = previous-tick hs 1, current-tick hs 0; vs falling edge likewise.
REQ-013 h_cnt (12b) SHALL load 0 on hs-fall tick, else increment, saturating at 4095.
REQ-014 On hs-fall tick: line length = h_cnt+1 (pre-load value); SHALL be written to O_line_period.
REQ-015 hs low width SHALL be counted per line; error if != C_H_SYNC_PULSE at the hs rising edge.
REQ-016 vs-fall SHALL set a pending flag; on the next hs-fall tick (or same tick), v_cnt loads 0 and flag clears, else v_cnt increments on each hs-fall tick, saturating at 4095.
REQ-017 On v_cnt load: frame length = v_cnt+1 -> O_frame_lines; vs low width in lines checked against C_V_SYNC_PULSE at vs rising edge.
REQ-018 Violation = line length != C_H_LINE_PERIOD, hs width mismatch, frame length != C_V_FRAME_PERIOD, vs width mismatch, or h_cnt reaching 4095 (sync lost); each SHALL mark current frame bad.
REQ-019 FSM states: SEARCH, CHECK, LOCKED.
REQ-020 SEARCH -> CHECK on first v_cnt load; good-frame count cleared.
REQ-021 CHECK: at each v_cnt load, good frame increments count, bad frame clears it; count = C_LOCK_FRAMES -> LOCKED.
REQ-022 LOCKED: any violation -> O_err pulse, count cleared, -> CHECK on the violating tick; sync-lost (h_cnt=4095) in any state -> SEARCH.
REQ-023 O_err SHALL also pulse for violations in CHECK after the first frame; never in SEARCH.
REQ-024 O_locked = 1 exactly when state is LOCKED, registered.
REQ-025 Active when h_cnt in [144,783] and v_cnt in [35,514] (from parameters); O_de = active AND LOCKED.
REQ-026 Latency: on each tick, O_de, O_x=h_cnt-144, O_y=v_cnt-35 and RGB SHALL update one I_clk cycle after that tick's sample and hold until next tick; O_de/RGB forced 0 when not active, O_x/O_y hold last value.
REQ-027 Simultaneous hs-fall and vs-fall on one tick SHALL start line 0 of a new frame on that tick.

Reset
REQ-028 I_rst_n=0 SHALL asynchronously clear all outputs to 0, FSM to SEARCH, counters/count/flags to 0, edge-detect history to 1 (idle high).
REQ-029 Reset mid-frame SHALL discard all measurements; lock requires C_LOCK_FRAMES full frames after release.

Verification
REQ-030 Standard 640x480 stimulus, ce every 2nd clk -> O_locked rises at 3rd vs-fall's first line; O_line_period=800, O_frame_lines=525, O_err never.
REQ-031 Locked, one line of 801 ticks -> O_err single pulse at that hs-fall, O_locked=0, relock after 2 good frames.
REQ-032 Locked, first active pixel (h_cnt 144, v_cnt 35) with RGB 1F/00/00 -> O_de=1, O_x=0, O_y=0, O_red=1F one clk after tick.
REQ-033 Last pixel h_cnt 783, v_cnt 514 -> O_x=639, O_y=479; h_cnt 784 -> O_de=0.
REQ-034 hs held high 5000 ticks -> state SEARCH, O_locked=0, h_cnt saturates 4095.
REQ-035 I_rst_n low mid-active-line while locked -> all outputs 0 immediately; after release O_locked stays 0 until 2 good frames.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// Recovers pixel timing from a VGA hs/vs stream: measures line/frame geometry,
// locks once timing matches the parameters, and emits active-area coordinates.
module vga_sync_decoder #(
    parameter int C_H_SYNC_PULSE   = 96,
    parameter int C_H_BACK_PORCH   = 48,
    parameter int C_H_ACTIVE_TIME  = 640,
    parameter int C_H_LINE_PERIOD  = 800,
    parameter int C_V_SYNC_PULSE   = 2,
    parameter int C_V_BACK_PORCH   = 33,
    parameter int C_V_ACTIVE_TIME  = 480,
    parameter int C_V_FRAME_PERIOD = 525,
    parameter int C_LOCK_FRAMES    = 2
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_pix_ce,
    input  logic        I_hs,
    input  logic        I_vs,
    input  logic [4:0]  I_red,
    input  logic [5:0]  I_green,
    input  logic [4:0]  I_blue,
    output logic [9:0]  O_x,
    output logic [8:0]  O_y,
    output logic        O_de,
    output logic [4:0]  O_red,
    output logic [5:0]  O_green,
    output logic [4:0]  O_blue,
    output logic        O_locked,
    output logic        O_err,
    output logic [11:0] O_line_period,
    output logic [11:0] O_frame_lines
);

    localparam logic [11:0] CNT_MAX     = 12'hFFF;
    localparam logic [11:0] H_SYNC      = 12'(C_H_SYNC_PULSE);
    localparam logic [11:0] H_LINE      = 12'(C_H_LINE_PERIOD);
    localparam logic [11:0] H_ACT_START = 12'(C_H_SYNC_PULSE + C_H_BACK_PORCH);
    localparam logic [11:0] H_ACT_END   = 12'(C_H_SYNC_PULSE + C_H_BACK_PORCH + C_H_ACTIVE_TIME - 1);
    localparam logic [11:0] V_SYNC      = 12'(C_V_SYNC_PULSE);
    localparam logic [11:0] V_FRAME     = 12'(C_V_FRAME_PERIOD);
    localparam logic [11:0] V_ACT_START = 12'(C_V_SYNC_PULSE + C_V_BACK_PORCH);
    localparam logic [11:0] V_ACT_END   = 12'(C_V_SYNC_PULSE + C_V_BACK_PORCH + C_V_ACTIVE_TIME - 1);
    localparam logic [7:0]  LOCK_CNT    = 8'(C_LOCK_FRAMES);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic        hs_prev, vs_prev;
    logic [11:0] h_cnt, v_cnt;
    logic        v_pend, frame_bad, first_frame;
    logic [1:0]  state;
    logic [7:0]  good_cnt;

    logic        hs_fall, hs_rise, vs_fall, vs_rise;
    logic        v_load, sync_lost, viol, frame_good, active, err_now;
    logic [11:0] h_next, v_next, h_len, v_len;
    logic [1:0]  state_n;
    logic [7:0]  good_cnt_n;
    logic        first_frame_n;

    always_comb begin
        hs_fall   = I_pix_ce & hs_prev & ~I_hs;
        hs_rise   = I_pix_ce & ~hs_prev & I_hs;
        vs_fall   = I_pix_ce & vs_prev & ~I_vs;
        vs_rise   = I_pix_ce & ~vs_prev & I_vs;
        h_len     = h_cnt + 12'd1;
        v_len     = v_cnt + 12'd1;
        h_next    = hs_fall ? 12'd0 : ((h_cnt == CNT_MAX) ? h_cnt : h_len);
        // A vs edge takes effect at the line start that coincides with or follows it.
        v_load    = hs_fall & (v_pend | vs_fall);
        v_next    = v_load ? 12'd0 : ((hs_fall && v_cnt != CNT_MAX) ? v_len : v_cnt);
        sync_lost = I_pix_ce & (h_cnt != CNT_MAX) & (h_next == CNT_MAX);
        viol      = (hs_fall && h_len != H_LINE) || (hs_rise && h_next != H_SYNC)
                 || (v_load && v_len != V_FRAME) || (vs_rise && v_next != V_SYNC)
                 || sync_lost;
        frame_good = ~(frame_bad | viol);
        active     = (h_next >= H_ACT_START) && (h_next <= H_ACT_END)
                  && (v_next >= V_ACT_START) && (v_next <= V_ACT_END);
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_n       = state;
        good_cnt_n    = good_cnt;
        first_frame_n = first_frame;
        err_now       = 1'b0;
        case (state)
            ST_SEARCH: begin
                if (v_load) begin
                    state_n       = ST_CHECK;
                    good_cnt_n    = 8'd0;
                    first_frame_n = 1'b1;
                end
            end
            ST_CHECK: begin
                err_now = viol & ~first_frame;
                if (v_load) begin
                    first_frame_n = 1'b0;
                    if (frame_good) begin
                        good_cnt_n = good_cnt + 8'd1;
                        if (good_cnt + 8'd1 == LOCK_CNT) state_n = ST_LOCKED;
                    end else begin
                        good_cnt_n = 8'd0;
                    end
                end
            end
            ST_LOCKED: begin
                if (viol) begin
                    err_now    = 1'b1;
                    good_cnt_n = 8'd0;
                    state_n    = ST_CHECK;
                end
            end
            default: state_n = ST_SEARCH;
        endcase
        if (sync_lost) begin
            state_n    = ST_SEARCH;
            good_cnt_n = 8'd0;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            hs_prev     <= 1'b1;
            vs_prev     <= 1'b1;
            h_cnt       <= 12'd0;
            v_cnt       <= 12'd0;
            v_pend      <= 1'b0;
            frame_bad   <= 1'b0;
            first_frame <= 1'b0;
            state       <= ST_SEARCH;
            good_cnt    <= 8'd0;
        end else if (I_pix_ce) begin
            hs_prev     <= I_hs;
            vs_prev     <= I_vs;
            h_cnt       <= h_next;
            v_cnt       <= v_next;
            v_pend      <= v_load ? 1'b0 : (v_pend | vs_fall);
            frame_bad   <= v_load ? 1'b0 : (frame_bad | viol);
            first_frame <= first_frame_n;
            state       <= state_n;
            good_cnt    <= good_cnt_n;
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_x           <= 10'd0;
            O_y           <= 9'd0;
            O_de          <= 1'b0;
            O_red         <= 5'd0;
            O_green       <= 6'd0;
            O_blue        <= 5'd0;
            O_locked      <= 1'b0;
            O_err         <= 1'b0;
            O_line_period <= 12'd0;
            O_frame_lines <= 12'd0;
        end else begin
            O_err    <= err_now;
            O_locked <= (state_n == ST_LOCKED);
            if (I_pix_ce) begin
                O_de    <= active & (state_n == ST_LOCKED);
                O_red   <= active ? I_red   : 5'd0;
                O_green <= active ? I_green : 6'd0;
                O_blue  <= active ? I_blue  : 5'd0;
                if (active) begin
                    O_x <= 10'(h_next - H_ACT_START);
                    O_y <= 9'(v_next - V_ACT_START);
                end
                if (hs_fall) O_line_period <= h_len;
                if (v_load)  O_frame_lines <= v_len;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a scaled-down 20x12 tick raster, pixel tick every 2nd clock.
module tb_vga_sync_decoder;

    localparam int HS = 4, HBP = 3, HACT = 8, HPER = 20;
    localparam int VS = 2, VBP = 3, VACT = 4, VPER = 12;

    logic        I_clk = 1'b0;
    logic        I_rst_n = 1'b0;
    logic        I_pix_ce = 1'b0;
    logic        I_hs = 1'b1, I_vs = 1'b1;
    logic [4:0]  I_red = '0, I_blue = '0;
    logic [5:0]  I_green = '0;
    logic [9:0]  O_x;
    logic [8:0]  O_y;
    logic        O_de, O_locked, O_err;
    logic [4:0]  O_red, O_blue;
    logic [5:0]  O_green;
    logic [11:0] O_line_period, O_frame_lines;

    int n_checks = 0;
    int n_errors = 0;
    int err_pulses = 0;
    int err_base;
    int hpos = 0, vline = 0;

    vga_sync_decoder #(
        .C_H_SYNC_PULSE(HS), .C_H_BACK_PORCH(HBP), .C_H_ACTIVE_TIME(HACT), .C_H_LINE_PERIOD(HPER),
        .C_V_SYNC_PULSE(VS), .C_V_BACK_PORCH(VBP), .C_V_ACTIVE_TIME(VACT), .C_V_FRAME_PERIOD(VPER),
        .C_LOCK_FRAMES(2)
    ) dut (
        .I_clk(I_clk), .I_rst_n(I_rst_n), .I_pix_ce(I_pix_ce), .I_hs(I_hs), .I_vs(I_vs),
        .I_red(I_red), .I_green(I_green), .I_blue(I_blue),
        .O_x(O_x), .O_y(O_y), .O_de(O_de), .O_red(O_red), .O_green(O_green), .O_blue(O_blue),
        .O_locked(O_locked), .O_err(O_err),
        .O_line_period(O_line_period), .O_frame_lines(O_frame_lines)
    );

    always #10 I_clk = ~I_clk;

    always @(negedge I_clk) if (O_err) err_pulses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One pixel tick: inputs set on a falling edge, sampled at the next rising edge,
    // returns on the following falling edge with outputs settled.
    task automatic drive(input logic hs, input logic vs,
                         input logic [4:0] r, input logic [5:0] g, input logic [4:0] b);
        @(negedge I_clk);
        I_hs = hs; I_vs = vs; I_red = r; I_green = g; I_blue = b;
        I_pix_ce = 1'b1;
        @(negedge I_clk);
        I_pix_ce = 1'b0;
    endtask

    task automatic pix(input logic [4:0] r, input logic [5:0] g, input logic [4:0] b);
        drive(hpos >= HS, vline >= VS, r, g, b);
        hpos++;
        if (hpos == HPER) begin
            hpos = 0;
            vline = (vline == VPER - 1) ? 0 : vline + 1;
        end
    endtask

    task automatic run_to(input int h, input int v);
        for (int i = 0; i < HPER * VPER && !(hpos == h && vline == v); i++) pix(0, 0, 0);
    endtask

    task automatic frame_start_locked(input string tag, input logic exp);
        run_to(0, 0);
        pix(0, 0, 0);
        check(tag, O_locked, exp);
    endtask

    initial begin
        repeat (3) @(negedge I_clk);
        check("rst_locked", O_locked, 0);
        check("rst_de", O_de, 0);
        check("rst_x", O_x, 0);
        check("rst_y", O_y, 0);
        check("rst_line", O_line_period, 0);
        check("rst_frame", O_frame_lines, 0);
        I_rst_n = 1'b1;

        // Lock-up from reset: first tick is the first vs-fall, lock at the third.
        pix(0, 0, 0);
        check("lock_t1", O_locked, 0);
        for (int i = 0; i < 2 * HPER * VPER - 1; i++) pix(0, 0, 0);
        check("lock_pre3", O_locked, 0);
        pix(0, 0, 0);
        check("lock_3rd", O_locked, 1);
        check("line_period", O_line_period, HPER);
        check("frame_lines", O_frame_lines, VPER);
        check("no_err_lockup", err_pulses, 0);

        // Active-area edges.
        run_to(6, 5);
        pix(5'h1F, 6'h3F, 5'h1F);
        check("pre_active_de", O_de, 0);
        check("pre_active_red", O_red, 0);
        pix(5'h1F, 6'h00, 5'h00);
        check("first_de", O_de, 1);
        check("first_x", O_x, 0);
        check("first_y", O_y, 0);
        check("first_red", O_red, 5'h1F);
        check("first_green", O_green, 0);
        run_to(14, 8);
        pix(5'h0A, 6'h2B, 5'h11);
        check("last_de", O_de, 1);
        check("last_x", O_x, HACT - 1);
        check("last_y", O_y, VACT - 1);
        check("last_green", O_green, 6'h2B);
        check("last_blue", O_blue, 5'h11);
        pix(5'h0A, 6'h2B, 5'h11);
        check("after_de", O_de, 0);
        check("after_red", O_red, 0);
        check("after_x_hold", O_x, HACT - 1);
        check("after_y_hold", O_y, VACT - 1);

        // One 21-tick line while locked.
        err_base = err_pulses;
        run_to(0, 11);
        drive(1'b1, 1'b1, 0, 0, 0);
        pix(0, 0, 0);
        check("long_err", O_err, 1);
        check("long_unlock", O_locked, 0);
        check("long_period", O_line_period, HPER + 1);
        pix(0, 0, 0);
        check("long_err_end", O_err, 0);
        frame_start_locked("relock_f0", 0);
        check("relock_frame", O_frame_lines, VPER);
        frame_start_locked("relock_f1", 0);
        frame_start_locked("relock_f2", 1);
        check("long_err_count", err_pulses - err_base, 1);

        // hs stuck high: sync lost.
        err_base = err_pulses;
        run_to(10, 6);
        repeat (5000) drive(1'b1, 1'b1, 0, 0, 0);
        check("lost_locked", O_locked, 0);
        check("lost_de", O_de, 0);
        check("lost_state", dut.state, 0);
        check("lost_hcnt", dut.h_cnt, 12'hFFF);
        check("lost_err_count", err_pulses - err_base, 1);

        // Recover, then reset mid-active-line while locked.
        err_base = err_pulses;
        frame_start_locked("recover_f0", 0);
        frame_start_locked("recover_f1", 0);
        frame_start_locked("recover_f2", 1);
        run_to(10, 6);
        pix(5'h03, 6'h04, 5'h05);
        check("mid_de", O_de, 1);
        check("mid_x", O_x, 3);
        check("mid_y", O_y, 1);
        #3 I_rst_n = 1'b0;
        #1;
        check("arst_locked", O_locked, 0);
        check("arst_de", O_de, 0);
        check("arst_x", O_x, 0);
        check("arst_y", O_y, 0);
        check("arst_red", O_red, 0);
        check("arst_line", O_line_period, 0);
        check("arst_frame", O_frame_lines, 0);
        @(negedge I_clk);
        I_rst_n = 1'b1;
        pix(0, 0, 0);
        check("post_rst_locked", O_locked, 0);
        frame_start_locked("post_rst_f0", 0);
        frame_start_locked("post_rst_f1", 0);
        frame_start_locked("post_rst_f2", 1);
        check("recover_err_count", err_pulses - err_base, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
